// File: rtl/pixel_frame_loader_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pixel_frame_loader_pkg : shared network parameters (frame geometry, state) | Rev 1.0
// ---------------------------------------------------------------------------
package pixel_frame_loader_pkg;

   localparam int NUM_PIXELS_DEF = 784;
   localparam int PIXEL_W_DEF    = 10;
   localparam int CNT_W          = 10;

   typedef enum logic [0:0] {
      LOAD = 1'b0,
      HOLD = 1'b1
   } state_e;

endpackage
`default_nettype wire

// File: rtl/pixel_frame_loader_pixel_index_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pixel_index_counter : write index for the frame buffer with last-slot detect | Rev 1.0
// ---------------------------------------------------------------------------
module pixel_index_counter
   import pixel_frame_loader_pkg::*;
#(
   parameter int NUM_PIXELS = NUM_PIXELS_DEF
) (
   input  logic             clk,
   input  logic             GlobalReset,
   input  logic             inc_i,
   input  logic             clr_i,
   output logic [CNT_W-1:0] count_o,
   output logic             last_o
);

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_PIXELS - 1);

   logic [CNT_W-1:0] count_d;
   logic [CNT_W-1:0] count_q;

   // Clear wins over increment: it covers both frame completion and aborts.
   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (inc_i) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge GlobalReset) begin
      if (!GlobalReset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;
   assign last_o  = (count_q == LAST_IDX);

endmodule
`default_nettype wire

// File: rtl/pixel_frame_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pixel_frame_loader : streams pixels into a flat frame bus and hands it off | Rev 1.0
// ---------------------------------------------------------------------------
module pixel_frame_loader
   import pixel_frame_loader_pkg::*;
#(
   parameter int NUM_PIXELS = NUM_PIXELS_DEF,
   parameter int PIXEL_W    = PIXEL_W_DEF
) (
   input  logic                          clk,
   input  logic                          GlobalReset,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [PIXEL_W-1:0]            in_pixel,
   input  logic                          in_last,
   output logic [NUM_PIXELS*PIXEL_W-1:0] Pixels,
   output logic                          frame_valid,
   output logic                          start,
   input  logic                          frame_ack,
   output logic [CNT_W-1:0]              pixel_count,
   output logic                          err_len
);

   state_e           state_q;
   logic             frame_valid_q;
   logic             start_q;
   logic             err_len_q;
   logic [PIXEL_W-1:0] pix_q [NUM_PIXELS];

   logic [CNT_W-1:0] idx;
   logic             at_last;
   logic             xfer;
   logic             cnt_inc;
   logic             cnt_clr;

   assign in_ready = (state_q == LOAD);
   assign xfer     = in_valid && in_ready;
   assign cnt_inc  = xfer && !at_last && !in_last;
   assign cnt_clr  = xfer && (at_last || in_last);

   pixel_index_counter #(
      .NUM_PIXELS (NUM_PIXELS)
   ) u_index (
      .clk         (clk),
      .GlobalReset (GlobalReset),
      .inc_i       (cnt_inc),
      .clr_i       (cnt_clr),
      .count_o     (idx),
      .last_o      (at_last)
   );

   // start and err_len are one-cycle pulses; they default low every cycle.
   always_ff @(posedge clk or negedge GlobalReset) begin
      if (!GlobalReset) begin
         state_q       <= LOAD;
         frame_valid_q <= 1'b0;
         start_q       <= 1'b0;
         err_len_q     <= 1'b0;
         for (int i = 0; i < NUM_PIXELS; i++) begin
            pix_q[i] <= '0;
         end
      end else begin
         start_q   <= 1'b0;
         err_len_q <= 1'b0;
         case (state_q)
            LOAD: begin
               if (xfer) begin
                  pix_q[idx] <= in_pixel;
                  if (at_last) begin
                     state_q       <= HOLD;
                     frame_valid_q <= 1'b1;
                     start_q       <= 1'b1;
                     err_len_q     <= !in_last;
                  end else if (in_last) begin
                     err_len_q <= 1'b1;
                  end
               end
            end
            HOLD: begin
               if (frame_ack) begin
                  state_q       <= LOAD;
                  frame_valid_q <= 1'b0;
               end
            end
            default: begin
               state_q <= LOAD;
            end
         endcase
      end
   end

   for (genvar g = 0; g < NUM_PIXELS; g++) begin : g_pack
      assign Pixels[g*PIXEL_W +: PIXEL_W] = pix_q[g];
   end

   assign frame_valid = frame_valid_q;
   assign start       = start_q;
   assign err_len     = err_len_q;
   assign pixel_count = idx;

endmodule
`default_nettype wire

// File: tb/tb_pixel_frame_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pixel_frame_loader : directed + randomized checks against a frame model | Rev 1.0
// ---------------------------------------------------------------------------
module tb_pixel_frame_loader;

   localparam int N = 784;
   localparam int W = 10;

   logic             clk = 1'b0;
   logic             GlobalReset;
   logic             in_valid;
   logic             in_ready;
   logic [W-1:0]     in_pixel;
   logic             in_last;
   logic [N*W-1:0]   Pixels;
   logic             frame_valid;
   logic             start;
   logic             frame_ack;
   logic [9:0]       pixel_count;
   logic             err_len;

   pixel_frame_loader #(.NUM_PIXELS(N), .PIXEL_W(W)) dut (
      .clk         (clk),
      .GlobalReset (GlobalReset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_pixel    (in_pixel),
      .in_last     (in_last),
      .Pixels      (Pixels),
      .frame_valid (frame_valid),
      .start       (start),
      .frame_ack   (frame_ack),
      .pixel_count (pixel_count),
      .err_len     (err_len)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Frame model: what the consumer should see after each clock.
   bit           m_hold;
   int           m_cnt;
   logic [N*W-1:0] m_bus;
   bit           m_start;
   bit           m_err;
   int           starts;
   int           errs;
   int           xfers;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      assert (act === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, act, exp);
      end
   endtask

   task automatic chk_bus(input string tag, input logic [N*W-1:0] exp);
      total++;
      assert (Pixels === exp) else begin
         bad++;
         $error("FAIL %s Pixels differs from expected frame (observed slot0=%0h expected slot0=%0h)",
                tag, Pixels[W-1:0], exp[W-1:0]);
      end
   endtask

   task automatic model_reset();
      m_hold = 0; m_cnt = 0; m_bus = '0; m_start = 0; m_err = 0;
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, ".in_ready"},    32'(in_ready),    32'(!m_hold));
      chk({tag, ".pixel_count"}, 32'(pixel_count), 32'(m_cnt));
      chk({tag, ".frame_valid"}, 32'(frame_valid), 32'(m_hold));
      chk({tag, ".start"},       32'(start),       32'(m_start));
      chk({tag, ".err_len"},     32'(err_len),     32'(m_err));
      chk_bus({tag, ".Pixels"}, m_bus);
   endtask

   // One clock: drive, let the edge happen, advance the model, compare.
   task automatic step(input bit v, input logic [W-1:0] p, input bit l, input bit a, input string tag);
      in_valid = v; in_pixel = p; in_last = l; frame_ack = a;
      @(posedge clk); #1;
      m_start = 0; m_err = 0;
      if (!m_hold && v) begin
         m_bus[m_cnt*W +: W] = p;
         xfers++;
         if (m_cnt == N - 1) begin
            m_hold = 1; m_start = 1; m_err = !l; m_cnt = 0;
         end else if (l) begin
            m_err = 1; m_cnt = 0;
         end else begin
            m_cnt++;
         end
      end else if (m_hold && a) begin
         m_hold = 0;
      end
      check_outputs(tag);
      starts += int'(start);
      errs   += int'(err_len);
   endtask

   initial begin
      #1000000;
      $display("FAIL timeout simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      int s0;
      int frames;
      int budget;
      logic [N*W-1:0] all_max;

      starts = 0; errs = 0; xfers = 0;
      GlobalReset = 1'b0;
      in_valid = 0; in_pixel = '0; in_last = 0; frame_ack = 0;
      model_reset();

      // Reset values while reset is held.
      #12;
      check_outputs("reset");
      #10 GlobalReset = 1'b1;
      #1 chk("post_reset.in_ready", 32'(in_ready), 32'd1);

      // Ramp frame i%4 with in_last on the final pixel.
      for (int i = 0; i < N; i++) step(1, W'(i % 4), i == N - 1, 0, "ramp");
      chk("ramp.start",       32'(start),              32'd1);
      chk("ramp.slot0",       32'(Pixels[9:0]),        32'd0);
      chk("ramp.slot1",       32'(Pixels[19:10]),      32'd1);
      chk("ramp.slot783",     32'(Pixels[7839:7830]),  32'd3);
      chk("ramp.err_count",   32'(errs),               32'd0);

      // Long hold with the source pushing; nothing may change.
      for (int i = 0; i < 50; i++) step(1, W'($urandom_range(0, 1023)), 0, 0, "hold");
      step(0, '0, 0, 1, "ack");
      chk("ack.in_ready",    32'(in_ready),    32'd1);
      chk("ack.pixel_count", 32'(pixel_count), 32'd0);

      // Early in_last aborts the frame, then a clean frame follows.
      s0 = starts;
      for (int i = 0; i < 100; i++) step(1, W'($urandom_range(0, 1023)), i == 99, 0, "abort");
      chk("abort.err_len", 32'(err_len),     32'd1);
      chk("abort.count",   32'(pixel_count), 32'd0);
      chk("abort.starts",  32'(starts - s0), 32'd0);
      for (int i = 0; i < N; i++) step(1, W'($urandom_range(0, 1023)), i == N - 1, 0, "clean");
      chk("clean.starts", 32'(starts - s0), 32'd1);
      step(0, '0, 0, 1, "clean_ack");

      // Missing in_last on the final pixel; ack lands in the first HOLD cycle.
      s0 = starts;
      for (int i = 0; i < N; i++) step(1, W'($urandom_range(0, 1023)), 0, 0, "nolast");
      chk("nolast.err_len",     32'(err_len),     32'd1);
      chk("nolast.start",       32'(start),       32'd1);
      chk("nolast.frame_valid", 32'(frame_valid), 32'd1);
      step(0, '0, 0, 1, "early_ack");
      step(0, '0, 0, 0, "early_ack_idle");
      chk("early_ack.starts", 32'(starts - s0), 32'd1);

      // Two all-1023 frames under random valid gaps and random ack delays.
      s0 = starts; frames = 0; budget = 0;
      while (frames < 2 && budget < 12000) begin
         if (m_hold) begin
            step($urandom_range(0, 1), 10'h3FF, 0, $urandom_range(0, 1), "gaps_hold");
         end else begin
            step($urandom_range(0, 1), 10'h3FF, m_cnt == N - 1, 0, "gaps");
            if (m_start) frames++;
         end
         budget++;
      end
      chk("gaps.budget", 32'(frames), 32'd2);
      chk("gaps.starts", 32'(starts - s0), 32'd2);
      all_max = {N{10'h3FF}};
      chk_bus("gaps.all1023", all_max);
      if (m_hold) step(0, '0, 0, 1, "gaps_ack");

      // Asynchronous reset partway through a frame.
      for (int i = 0; i < 400; i++) step(1, W'($urandom_range(1, 1023)), 0, 0, "partial");
      #2 GlobalReset = 1'b0;
      #1;
      model_reset();
      check_outputs("async_reset");
      #2 GlobalReset = 1'b1;
      xfers = 0; s0 = starts;
      for (int i = 0; i < N; i++) step(1, W'($urandom_range(0, 1023)), i == N - 1, 0, "after_reset");
      chk("after_reset.start", 32'(start),        32'd1);
      chk("after_reset.xfers", 32'(xfers),        32'd784);
      chk("after_reset.starts", 32'(starts - s0), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pixel_frame_loader.md
PIXEL_FRAME_LOADER -- requirements
Module: pixel_frame_loader

Interface
REQ-001 Parameter NUM_PIXELS, default 784, SHALL set the pixels per frame.
REQ-002 Parameter PIXEL_W, default 10, SHALL set the width of one pixel.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 GlobalReset  input  1  SHALL be an asynchronous, active-low reset.
REQ-005 in_valid  input  1  SHALL mark in_pixel/in_last as valid.
REQ-006 in_ready  output  1  SHALL indicate the loader accepts a pixel this cycle.
REQ-007 in_pixel  input  PIXEL_W  SHALL carry one unsigned pixel value.
REQ-008 in_last  input  1  SHALL mark the final pixel of a frame.
REQ-009 Pixels  output  NUM_PIXELS*PIXEL_W (7840)  SHALL be the flat frame bus feeding the dot-product engine; pixel i at bits [i*PIXEL_W +: PIXEL_W].
REQ-010 frame_valid  output  1  SHALL indicate Pixels holds a complete, stable frame.
REQ-011 start  output  1  SHALL pulse one cycle when a frame becomes complete.
REQ-012 frame_ack  input  1  SHALL be asserted by the engine when it has finished consuming Pixels.
REQ-013 pixel_count  output  10  SHALL report pixels accepted in the current frame.
REQ-014 err_len  output  1  SHALL pulse one cycle on a frame-length violation.

Function
REQ-015 States SHALL be LOAD and HOLD only.
REQ-016 in_ready SHALL equal (state == LOAD), decoded combinationally from the state register.
REQ-017 A transfer SHALL occur when in_valid && in_ready on a rising edge.
REQ-018 On a transfer at index k = pixel_count, Pixels slot k SHALL take in_pixel and be visible the next cycle; other slots unchanged.
REQ-019 Transfers at k < NUM_PIXELS-1 without in_last SHALL increment pixel_count.
REQ-020 Transfer at k = NUM_PIXELS-1 SHALL move LOAD->HOLD, reset pixel_count to 0, and assert frame_valid and start in the following cycle.
REQ-021 If that final transfer lacks in_last, err_len SHALL pulse the next cycle; the frame SHALL still complete.
REQ-022 in_last on a transfer at k < NUM_PIXELS-1 SHALL pulse err_len next cycle, write the pixel, reset pixel_count to 0, and remain in LOAD (frame aborted, no start).
REQ-023 In HOLD, frame_valid SHALL stay 1, Pixels SHALL be stable, and start SHALL be 1 only in the first HOLD cycle.
REQ-024 frame_ack in HOLD SHALL move to LOAD next cycle with frame_valid 0; frame_ack in LOAD SHALL be ignored.
REQ-025 frame_ack in the first HOLD cycle (simultaneous with start) SHALL be honoured; start still pulses exactly once.
REQ-026 Pixels SHALL not be cleared between frames; slots are overwritten as the next frame loads.
REQ-027 in_valid while in HOLD SHALL have no effect; the source holds data until in_ready.

Reset
REQ-028 While GlobalReset is low: state = LOAD, pixel_count = 0, Pixels = 0, frame_valid = 0, start = 0, err_len = 0; in_ready = 1 after release.
REQ-029 Reset asserted mid-frame or in HOLD SHALL discard the frame immediately, independent of clk.

Structure
REQ-030 NUM_PIXELS, PIXEL_W, the count width (10) and the state encoding SHALL live in a shared network-parameters package used by the engine too.
REQ-031 One sub-module, pixel_index_counter (count, last-index detect, clear), SHALL be instantiated; all else inline.

Verification
REQ-032 Stream pixel i = i%4 for i = 0..783, in_valid always high, in_last on i = 783 -> start pulses the cycle after the 784th transfer; Pixels[9:0] = 0, Pixels[19:10] = 1, Pixels[7839:7830] = 3; err_len never asserts.
REQ-033 Full frame, hold frame_ack low 50 cycles with in_valid high -> in_ready 0, Pixels unchanged, frame_valid 1 throughout; ack -> LOAD next cycle, pixel_count = 0.
REQ-034 in_last on pixel index 99 -> err_len one pulse, pixel_count = 0, no start; following clean 784-pixel frame completes normally.
REQ-035 784th pixel without in_last -> err_len pulse and start in the same cycle, frame_valid 1.
REQ-036 Random in_valid gaps (50% duty) over two frames of value 1023 -> every slot = 1023, exactly two start pulses.
REQ-037 GlobalReset low after 400 pixels -> all outputs 0 asynchronously; after release, a 784-pixel frame completes with start after exactly 784 transfers.
